// File: rtl/out_capture_fifo_pkg.sv
// Shared definitions for the output select stage and its capture FIFO:
// sample source tags and default sizing.
package out_capture_fifo_pkg;

  typedef enum logic [1:0] {
    TAG_DEF  = 2'd0,
    TAG_X    = 2'd1,
    TAG_Y    = 2'd2,
    TAG_RSVD = 2'd3
  } tag_e;

  localparam int DEFAULT_W     = 8;
  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/out_capture_fifo_sat_counter8.sv
// 8-bit incrementer that sticks at 255 instead of wrapping.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'd0;
    end else if (inc && (value != 8'hFF)) begin
      value <= value + 8'd1;
    end
  end

endmodule

// File: rtl/out_capture_fifo.sv
// First-word-fall-through capture FIFO for tagged output samples, with a
// saturating count of samples it had to reject.
module out_capture_fifo
  import out_capture_fifo_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  input  logic [1:0]               in_tag,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [1:0]               out_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W+1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          tag_ok;
  logic          push;
  logic          pop;
  logic          reject;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign {out_tag, out_data} = mem[rd_ptr];

  // Acceptance depends only on registered fullness, so a same-edge pop
  // never opens room for a push.
  assign tag_ok = (in_tag != TAG_RSVD);
  assign push   = in_valid && !full && tag_ok && !flush;
  assign pop    = out_valid && out_ready && !flush;
  assign reject = in_valid && !flush && (full || !tag_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_tag, in_data};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  sat_counter8 u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (reject),
    .value (drop_cnt)
  );

endmodule

// File: tb/tb_out_capture_fifo.sv
// Randomized and directed bench for out_capture_fifo against a queue model.
module tb_out_capture_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_tag = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_tag;
  logic         full;
  logic         empty;
  logic [2:0]   count;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [W+1:0] mq[$];
  int           mdrop = 0;

  out_capture_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue plus a drop tally.
  bit m_pop, m_push, m_full;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mdrop = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = in_valid && !m_full && (in_tag != 2'd3);
      if (in_valid && (m_full || in_tag == 2'd3) && mdrop < 255) mdrop++;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({in_tag, in_data});
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_drop", drop_cnt, 0);
    end else begin
      check("out_valid", out_valid, int'(mq.size() > 0));
      check("count", count, mq.size());
      check("full", full, int'(mq.size() == DEPTH));
      check("empty", empty, int'(mq.size() == 0));
      check("drop_cnt", drop_cnt, mdrop);
      if (mq.size() > 0) begin
        check("out_data", out_data, mq[0][W-1:0]);
        check("out_tag", out_tag, mq[0][W+1:W]);
      end
    end
  end

  task automatic cyc(input bit v, input logic [1:0] t, input logic [W-1:0] d,
                     input bit r, input bit f);
    in_valid  = v;
    in_tag    = t;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; flush = 0; in_tag = 0; in_data = 0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_empty", empty, 1);
    check("init_drop", drop_cnt, 0);
    rst_n = 1'b1;

    // First-sample latency
    do_reset();
    cyc(1, 2'd1, 8'h11, 0, 0);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'h11);
    check("lat_tag", out_tag, 1);
    check("lat_count", count, 1);

    // Overflow while filling, then ordered drain
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1, 2'd0, 8'(i), 0, 0);
    check("ovf_full", full, 1);
    check("ovf_count", count, 4);
    check("ovf_drop", drop_cnt, 1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", out_data, i);
      cyc(0, 2'd0, 8'h00, 1, 0);
    end
    check("drain_empty", empty, 1);

    // Steady push+pop across pointer wrap
    do_reset();
    cyc(1, 2'd2, 8'h20, 0, 0);
    cyc(1, 2'd2, 8'h21, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 2'd1, 8'(8'h30 + i), 1, 0);
      check("stream_count", count, 2);
    end
    check("stream_head", out_data, 8'h38);
    check("stream_head_tag", out_tag, 1);

    // Pop while full does not admit a push
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 2'd0, 8'(8'hA0 + i), 0, 0);
    cyc(1, 2'd2, 8'hEE, 1, 0);
    check("fullpop_count", count, 3);
    check("fullpop_drop", drop_cnt, 1);
    check("fullpop_head", out_data, 8'hA1);

    // Reserved tag is dropped
    do_reset();
    cyc(1, 2'd3, 8'h77, 0, 0);
    check("rsvd_count", count, 0);
    check("rsvd_drop", drop_cnt, 1);

    // Drop saturation, then flush with a live sample
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 2'd0, 8'(i), 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, 2'd1, 8'hF0, 0, 0);
    check("sat_drop", drop_cnt, 255);
    cyc(1, 2'd0, 8'h99, 1, 1);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_drop", drop_cnt, 255);
    cyc(1, 2'd2, 8'h42, 0, 0);
    check("postflush_data", out_data, 8'h42);
    check("postflush_count", count, 1);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 2'd1, 8'(8'h60 + i), 0, 0);
    cyc(1, 2'd3, 8'h00, 0, 0);
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_drop", drop_cnt, 0);
    check("async_count", count, 0);
    rst_n = 1'b1;
    cyc(1, 2'd2, 8'h55, 0, 0);
    check("async_head", out_data, 8'h55);
    check("async_head_count", count, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
          8'($urandom),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 31) == 0);
    end
    cyc(0, 2'd0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_capture_fifo.md
OUT_CAPTURE_FIFO -- requirements
Module: out_capture_fifo

Interface
REQ-001 Parameter W, default 8: data width of each captured output sample.
REQ-002 Parameter DEPTH, default 4: number of entries; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream select stage presents a sample this cycle.
REQ-006 in_data  input  W  sample value (the upstream stage's registered out).
REQ-007 in_tag  input  2  source of sample: 0 default, 1 x-path, 2 y-path; 3 is reserved.
REQ-008 flush  input  1  synchronous request to discard all stored entries.
REQ-009 out_ready  input  1  downstream accepts the head entry.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_data  output  W  head entry data.
REQ-012 out_tag  output  2  head entry tag.
REQ-013 full  output  1  count equals DEPTH.
REQ-014 empty  output  1  count equals 0.
REQ-015 count  output  log2(DEPTH)+1  number of stored entries.
REQ-016 drop_cnt  output  8  saturating count of rejected samples.

Function
REQ-017 Push SHALL occur on a clock edge when in_valid=1, full=0 and flush=0; {in_tag,in_data} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-018 Pop SHALL occur on a clock edge when out_valid=1, out_ready=1 and flush=0; rd_ptr increments modulo DEPTH.
REQ-019 Storage is first-word-fall-through: out_valid = !empty, and out_data/out_tag = entry at rd_ptr, with no extra read latency.
REQ-020 Latency: a sample pushed at edge N SHALL appear at the outputs in the cycle after edge N if the FIFO was empty.
REQ-021 Simultaneous push and pop when 0<count<DEPTH SHALL leave count unchanged and both pointers advanced.
REQ-022 When full, a push attempt SHALL be rejected even if a pop occurs at the same edge; there is no combinational out_ready-to-input path.
REQ-023 A rejected push (in_valid=1, full=1, flush=0) SHALL increment drop_cnt by 1; drop_cnt SHALL saturate at 255 and never wrap.
REQ-024 Samples with in_tag=3 SHALL be rejected and counted in drop_cnt like overflow drops.
REQ-025 flush=1 SHALL, at the next edge, set rd_ptr=wr_ptr=0 and count=0, and ignore same-cycle push and pop; drop_cnt is not incremented and not cleared.
REQ-026 count SHALL track pushes minus pops exactly; full and empty SHALL be derived from count, never from pointer equality alone.
REQ-027 Pop on empty and push on full SHALL be no-ops for pointers and storage.

Reset
REQ-028 Assertion of rst_n=0 SHALL, without waiting for clk, clear rd_ptr, wr_ptr, count, drop_cnt and all storage entries.
REQ-029 During reset: out_valid=0, out_data=0, out_tag=0, empty=1, full=0, count=0, drop_cnt=0.
REQ-030 Reset asserted during an operation SHALL discard all entries; the first push after deassertion is stored at index 0.

Structure
REQ-031 A shared include/package SHALL hold the tag encodings (TAG_DEF=0, TAG_X=1, TAG_Y=2, TAG_RSVD=3) and the default DEPTH and W, for use by the upstream select stage and this block.
REQ-032 The drop counter SHALL be one sub-module, sat_counter8: an 8-bit saturating incrementer with asynchronous active-low reset.
REQ-033 Storage SHALL be a register array of DEPTH entries of W+2 bits; no memory macro.

Verification
REQ-034 Reset then push 0x11/tag1 with out_ready=0 -> next cycle out_valid=1, out_data=0x11, out_tag=1, count=1.
REQ-035 Push 5 samples (0x01..0x05) with out_ready=0 at DEPTH=4 -> full=1, count=4, drop_cnt=1; draining returns 0x01..0x04 in order.
REQ-036 With count=2, hold in_valid=1 and out_ready=1 for 10 cycles -> count stays at 2, outputs in order, and the pointers wrap past index 3 correctly.
REQ-037 While full, assert in_valid and out_ready together -> one pop, no push, drop_cnt+1, count=3.
REQ-038 Drive 300 overflow drops, then flush with in_valid=1 -> drop_cnt=255, count=0, empty=1, and the flush-cycle sample is neither stored nor counted.
REQ-039 Assert rst_n=0 between edges with count=3 -> out_valid falls immediately and drop_cnt=0; the next push appears as the head.
